ifu_fetch_queue: RTL and testbench



---
 rtl/ifu_fetch_queue_pkg.sv | 28 ++
 rtl/fetch_sync_fifo.sv | 83 ++++++++
 rtl/ifu_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_queue_pkg.sv
// Shared widths, reset PC and redirect bus layout for the instruction fetch queue.
// The redirect helper resolves flush-over-branch priority into one {taken, target} bus.
package ifu_fetch_queue_pkg;

  localparam int unsigned FQ_PC_WD   = 64;
  localparam int unsigned FQ_INST_WD = 32;
  localparam int unsigned FQ_BUS_WD  = FQ_INST_WD + FQ_PC_WD;

  localparam logic [FQ_PC_WD-1:0] FQ_RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic                taken;
    logic [FQ_PC_WD-1:0] target;
  } redirect_t;

  function automatic redirect_t pick_redirect(
    input logic                flush,
    input logic [FQ_PC_WD-1:0] flush_pc,
    input logic                br_taken,
    input logic [FQ_PC_WD-1:0] br_target
  );
    redirect_t r;
    r.taken  = flush | br_taken;
    r.target = flush ? flush_pc : br_target;
    return r;
  endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// Synchronous FIFO with clear; push and pop may coincide at any occupancy, including full.
// Depth need not be a power of two, so pointers wrap explicitly.
module fetch_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    full_o  = (count_q == DepthCnt);
    empty_o = (count_q == '0);
    count_o = count_q;
    rdata_o = mem_q[rptr_q];

    // A pop frees the head slot in the same edge, so a push into a full FIFO is safe then.
    do_push = push_i & ~clr_i & (~full_o | pop_i);
    do_pop  = pop_i & ~clr_i & ~empty_o;

    mem_d = mem_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
    end

    wptr_d  = do_push ? next_ptr(wptr_q) : wptr_q;
    rptr_d  = do_pop ? next_ptr(rptr_q) : rptr_q;
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);

    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_i && !clr_i && full_o && !pop_i));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop_i && !clr_i && empty_o));

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch stage with a decoupling queue toward decode and up to MAX_OUTSTANDING in-order
// memory requests; responses belonging to a pre-redirect path are counted off and dropped.
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int unsigned      PC_WD           = FQ_PC_WD,
  parameter int unsigned      INST_WD         = FQ_INST_WD,
  parameter int unsigned      DATA_WD         = 64,
  parameter int unsigned      FQ_DEPTH        = 4,
  parameter int unsigned      MAX_OUTSTANDING = 2,
  parameter logic [PC_WD-1:0] RESET_PC        = FQ_RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     br_taken,
  input  logic [PC_WD-1:0]         br_target,
  input  logic                     flush,
  input  logic [PC_WD-1:0]         flush_pc,
  output logic                     inst_req_valid,
  input  logic                     inst_req_ready,
  output logic [PC_WD-1:0]         inst_req_addr,
  input  logic                     inst_resp_valid,
  input  logic [DATA_WD-1:0]       inst_resp_data,
  input  logic                     ds_allowin,
  output logic                     fs_to_ds_valid,
  output logic [INST_WD+PC_WD-1:0] fs_to_ds_bus
);

  localparam int unsigned BusWd    = INST_WD + PC_WD;
  localparam int unsigned CntW     = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned PendCntW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned HalfSel  = $clog2(INST_WD / 8);

  localparam logic [PC_WD-1:0] PcStep   = PC_WD'(INST_WD / 8);
  localparam logic [CntW-1:0]  MaxOut   = CntW'(MAX_OUTSTANDING);
  localparam logic [CntW:0]    DepthLim = (CntW + 1)'(FQ_DEPTH);

  logic [PC_WD-1:0]    fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]     inflight_q, inflight_d;
  logic [CntW-1:0]     drop_cnt_q, drop_cnt_d;
  logic                run_q, run_d;

  redirect_t           redir;
  logic                redirect;
  logic [PC_WD-1:0]    target;
  logic [CntW:0]       credit_used;
  logic                req_fire;
  logic                resp_drop;

  logic                fq_push, fq_pop, fq_full, fq_empty;
  logic [BusWd-1:0]    fq_wdata, fq_rdata;
  logic [CntW-1:0]     fq_count;

  logic                pend_full, pend_empty;
  logic [PC_WD-1:0]    resp_pc;
  logic [PendCntW-1:0] pend_count;
  logic [INST_WD-1:0]  resp_inst;

  if (DATA_WD == 2 * INST_WD) begin : g_wide_data
    assign resp_inst = resp_pc[HalfSel] ? inst_resp_data[DATA_WD-1:INST_WD]
                                        : inst_resp_data[INST_WD-1:0];
  end else begin : g_narrow_data
    assign resp_inst = inst_resp_data[INST_WD-1:0];
  end

  always_comb begin
    redir    = pick_redirect(flush, FQ_PC_WD'(flush_pc), br_taken, FQ_PC_WD'(br_target));
    redirect = redir.taken;
    target   = PC_WD'(redir.target);

    // Every in-flight request owns a queue slot, so the queue can never overflow.
    credit_used    = {1'b0, inflight_q} + {1'b0, fq_count};
    inst_req_valid = ~reset & run_q & ~redirect & (inflight_q < MaxOut) &
                     (credit_used < DepthLim);
    inst_req_addr  = fetch_pc_q;
    req_fire       = inst_req_valid & inst_req_ready;

    resp_drop = inst_resp_valid & (drop_cnt_q != '0);
    fq_push   = inst_resp_valid & ~resp_drop & ~redirect;
    fq_wdata  = {resp_inst, resp_pc};

    fs_to_ds_valid = ~reset & ~fq_empty & ~redirect;
    fs_to_ds_bus   = fq_rdata;
    fq_pop         = fs_to_ds_valid & ds_allowin;

    inflight_d = inflight_q + CntW'(req_fire) - CntW'(inst_resp_valid);

    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      // Recount from inflight so responses already dropped are not counted twice.
      drop_cnt_d = inflight_q - CntW'(inst_resp_valid);
    end else if (resp_drop) begin
      drop_cnt_d = drop_cnt_q - CntW'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = target;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PcStep;
    end

    run_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      run_q      <= run_d;
    end
  end

  fetch_sync_fifo #(
    .Width (BusWd),
    .Depth (FQ_DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (redirect),
    .push_i  (fq_push),
    .wdata_i (fq_wdata),
    .pop_i   (fq_pop),
    .rdata_o (fq_rdata),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_count)
  );

  // Never cleared on redirect: its entries must stay aligned with responses still due.
  fetch_sync_fifo #(
    .Width (PC_WD),
    .Depth (MAX_OUTSTANDING)
  ) u_pending_pc (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (inst_resp_valid),
    .rdata_o (resp_pc),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .count_o (pend_count)
  );

  a_pending_tracks_inflight: assert property (@(posedge clk) disable iff (reset)
    inflight_q == CntW'(pend_count));

  a_no_req_past_limit: assert property (@(posedge clk) disable iff (reset)
    !(req_fire && pend_full));

  a_no_unsolicited_resp: assert property (@(posedge clk) disable iff (reset)
    !(inst_resp_valid && pend_empty));

  a_queue_credit: assert property (@(posedge clk) disable iff (reset)
    !(fq_push && fq_full && !fq_pop));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: an in-order memory model with configurable latency,
// a queue-level reference model compared every cycle, and literal checks on key scenarios.
module tb_ifu_fetch_queue;
  import ifu_fetch_queue_pkg::*;

  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned DEPTH   = 4;
  localparam logic [63:0] RST_PC  = 64'h8000_0000;

  logic                 clk = 1'b0;
  logic                 reset, br_taken, flush;
  logic [63:0]          br_target, flush_pc;
  logic                 inst_req_valid, inst_req_ready;
  logic [63:0]          inst_req_addr;
  logic                 inst_resp_valid;
  logic [63:0]          inst_resp_data;
  logic                 ds_allowin, fs_to_ds_valid;
  logic [FQ_BUS_WD-1:0] fs_to_ds_bus;

  always #5 clk = ~clk;

  ifu_fetch_queue dut (
    .clk             (clk),
    .reset           (reset),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .inst_req_valid  (inst_req_valid),
    .inst_req_ready  (inst_req_ready),
    .inst_req_addr   (inst_req_addr),
    .inst_resp_valid (inst_resp_valid),
    .inst_resp_data  (inst_resp_data),
    .ds_allowin      (ds_allowin),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem[$];

  // Reference model state: addresses in flight, queued {inst, pc}, responses still to drop.
  logic [63:0]          m_infl[$];
  logic [FQ_BUS_WD-1:0] m_fq[$];
  int                   m_drop;
  logic [63:0]          m_pc;
  bit                   m_started;

  logic [FQ_BUS_WD-1:0] delivered[$];
  int                   deliv_cyc[$];
  logic [63:0]          issued[$];

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [63:0] line_data(input logic [63:0] a);
    logic [63:0] base;
    base = {a[63:3], 3'b000};
    if (base == 64'h8000_0000) return 64'h1111_1111_2222_2222;
    return {word_at(base + 64'd4), word_at(base)};
  endfunction

  function automatic logic [31:0] pick_inst(input logic [63:0] d, input logic [63:0] a);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  function automatic logic [FQ_BUS_WD-1:0] deliv_at(input int i);
    if (i < delivered.size()) return delivered[i];
    return '0;
  endfunction

  function automatic int deliv_cyc_at(input int i);
    if (i < deliv_cyc.size()) return deliv_cyc[i];
    return -1;
  endfunction

  function automatic logic [63:0] issued_at(input int i);
    if (i < issued.size()) return issued[i];
    return '0;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the edge, compare and advance the model mid-cycle.
  task automatic cycle(input bit rst, input bit fl, input logic [63:0] fpc, input bit br,
                       input logic [63:0] bt, input bit allow, input bit rdy);
    bit          red, rv, fv, resp;
    logic [63:0] rdata, a;
    @(posedge clk);
    #1;
    reset          = rst;
    flush          = fl;
    flush_pc       = fpc;
    br_taken       = br;
    br_target      = bt;
    ds_allowin     = allow;
    inst_req_ready = rdy;
    resp  = 1'b0;
    rdata = '0;
    if (rst) begin
      mem.delete();
    end else if (mem.size() > 0 && mem[0].due <= cyc) begin
      resp  = 1'b1;
      rdata = line_data(mem[0].addr);
      mem.delete(0);
    end
    inst_resp_valid = resp;
    inst_resp_data  = rdata;

    @(negedge clk);
    red = fl | br;
    rv  = !rst && m_started && !red && (m_infl.size() < MAX_OUT) &&
          (m_infl.size() + m_fq.size() < DEPTH);
    fv  = !rst && !red && (m_fq.size() > 0);
    check("req_valid", inst_req_valid, rv);
    if (rv) check("req_addr", inst_req_addr, m_pc);
    check("fs_valid", fs_to_ds_valid, fv);
    if (fv) check("fs_bus", fs_to_ds_bus, m_fq[0]);

    if (fs_to_ds_valid && allow) begin
      delivered.push_back(fs_to_ds_bus);
      deliv_cyc.push_back(cyc);
    end
    if (!rst && inst_req_valid && rdy) begin
      issued.push_back(inst_req_addr);
      mem.push_back('{addr: inst_req_addr, due: cyc + lat});
    end

    if (rst) begin
      m_pc      = RST_PC;
      m_drop    = 0;
      m_started = 1'b0;
      m_fq.delete();
      m_infl.delete();
    end else begin
      if (fv && allow) m_fq.delete(0);
      if (resp && m_infl.size() > 0) begin
        a = m_infl.pop_front();
        if (m_drop > 0) m_drop--;
        else if (!red) m_fq.push_back({pick_inst(rdata, a), a});
      end
      if (red) begin
        m_fq.delete();
        m_drop = m_infl.size();
        m_pc   = fl ? fpc : bt;
      end else if (rv && rdy) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
      m_started = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit allow);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, allow, 1'b1);
  endtask

  initial begin
    int  base, rel, ibase;
    bit  found;
    reset = 1'b1; flush = 1'b0; br_taken = 1'b0; flush_pc = '0; br_target = '0;
    inst_req_ready = 1'b1; inst_resp_valid = 1'b0; inst_resp_data = '0; ds_allowin = 1'b1;
    m_pc = RST_PC; m_drop = 0; m_started = 1'b0;

    // Reset release, free-running fetch with 1-cycle memory.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    rel  = cyc;
    base = delivered.size();
    idle(10, 1'b1);
    check("first_deliv_latency", deliv_cyc_at(base) - rel, 3);
    check("first_entry", deliv_at(base), {32'h2222_2222, 64'h8000_0000});
    check("second_entry", deliv_at(base + 1), {32'h1111_1111, 64'h8000_0004});
    check("first_req_addr", issued_at(0), 64'h8000_0000);

    // Decode stalled: queue fills to depth and request issue stops.
    idle(20, 1'b0);
    check("stall_req_valid", inst_req_valid, 1'b0);
    check("stall_fs_valid", fs_to_ds_valid, 1'b1);
    check("stall_fq_count", dut.fq_count, 4);
    idle(8, 1'b1);

    // Branch with two requests in flight and none returning for two cycles.
    lat = 4;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_infl.size() == 2 && mem.size() == 2 && mem[0].due > cyc + 1) found = 1'b1;
      else idle(1, 1'b1);
    end
    check("branch_setup", found, 1'b1);
    base = delivered.size();
    cycle(1'b0, 1'b0, '0, 1'b1, 64'h8000_0100, 1'b1, 1'b1);
    check("branch_cycle_fs_valid", fs_to_ds_valid, 1'b0);
    idle(1, 1'b1);
    check("branch_drop_cnt", dut.drop_cnt_q, 2);
    check("branch_queue_cleared", dut.fq_count, 0);
    idle(15, 1'b1);
    check("branch_first_pc", deliv_at(base), {word_at(64'h8000_0100), 64'h8000_0100});

    // Flush and branch together while a response lands in the same cycle.
    lat = 2;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_infl.size() == 2 && mem.size() == 2 && mem[0].due <= cyc) found = 1'b1;
      else idle(1, 1'b1);
    end
    check("flush_setup", found, 1'b1);
    base  = delivered.size();
    ibase = issued.size();
    cycle(1'b0, 1'b1, 64'h8000_0200, 1'b1, 64'h8000_0300, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("flush_drop_cnt", dut.drop_cnt_q, 1);
    check("flush_resume_addr", issued_at(ibase), 64'h8000_0200);
    idle(12, 1'b1);
    check("flush_first_pc", deliv_at(base), {word_at(64'h8000_0200), 64'h8000_0200});

    // Reset with queued entries and requests in flight.
    lat = 3;
    idle(6, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    base = delivered.size();
    idle(1, 1'b1);
    check("rst_fs_valid", fs_to_ds_valid, 1'b0);
    check("rst_inflight", dut.inflight_q, 0);
    check("rst_fetch_pc", inst_req_addr, 64'h8000_0000);
    idle(8, 1'b1);
    check("rst_first_entry", deliv_at(base), {32'h2222_2222, 64'h8000_0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its summary within 100000 time units");
    $fatal(1);
  end

endmodule
